// File: rtl/cpu4_pkg.sv
// Shared opcodes, sequencer state encoding and instruction-word field helpers
// for the host side of the 4-bit accumulator CPU.
package cpu4_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_NOP   = 4'hF;

  localparam int INSTR_W = 12;
  localparam int OPC_HI  = 11;
  localparam int OPC_LO  = 8;
  localparam int ADDR_HI = 7;
  localparam int ADDR_LO = 4;
  localparam int DATA_HI = 3;
  localparam int DATA_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_REPORT = 3'd3
  } seq_state_t;

  function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] w);
    return w[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [3:0] instr_addr(input logic [INSTR_W-1:0] w);
    return w[ADDR_HI:ADDR_LO];
  endfunction

  function automatic logic [3:0] instr_data(input logic [INSTR_W-1:0] w);
    return w[DATA_HI:DATA_LO];
  endfunction

endpackage

// File: rtl/cpu4_prog_buffer.sv
// Program store: DEPTH instruction words, one synchronous write port and one
// asynchronous read port. Contents survive reset so a program can be replayed.
module cpu4_prog_buffer
  import cpu4_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu4_instr_sequencer.sv
// Buffers {opcode,addr,data} words and replays them to the CPU one pulse at a time,
// returning each sampled result nibble over a valid/ready stream.
module cpu4_instr_sequencer
  import cpu4_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  HOLD  = 6,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_word,
  input  logic               prog_clr,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [3:0]         cpu_opcode,
  output logic [3:0]         cpu_addr,
  output logic [3:0]         cpu_data,
  output logic               cpu_write_enable,
  input  logic [7:0]         cpu_result,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [3:0]         res_data,
  output logic [AW-1:0]      res_index
);

  localparam int          HW        = $clog2(HOLD);
  localparam int          HOLD_M2   = HOLD - 2;
  localparam logic [HW-1:0] HOLD_LAST = HOLD_M2[HW-1:0];
  localparam logic [AW:0] FULL      = DEPTH[AW:0];

  seq_state_t         state, state_nxt;
  logic [AW:0]        prog_len;
  logic [AW-1:0]      pc;
  logic [HW-1:0]      hold_cnt;
  logic [INSTR_W-1:0] cur_word;
  logic               load_fire, start_req, start_go, start_empty;
  logic               res_fire, last_instr, cur_is_store;
  logic               unused_result_low;

  // Only the high nibble of the CPU output carries the result.
  assign unused_result_low = ^cpu_result[3:0];

  cpu4_prog_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .wr_en   (load_fire),
    .wr_addr (prog_len[AW-1:0]),
    .wr_data (load_word),
    .rd_addr (pc),
    .rd_data (cur_word)
  );

  assign busy         = (state != ST_IDLE);
  assign load_ready   = !rst && (state == ST_IDLE) && (prog_len != FULL);
  assign load_fire    = load_valid && load_ready && !prog_clr;
  assign start_req    = (state == ST_IDLE) && start && !prog_clr;
  // A word loaded in the start cycle counts toward the run length.
  assign start_go     = start_req && ((prog_len != '0) || load_fire);
  assign start_empty  = start_req && (prog_len == '0) && !load_fire;
  assign res_fire     = (state == ST_REPORT) && res_ready;
  assign last_instr   = ({1'b0, pc} == (prog_len - 1'b1));
  assign cur_is_store = (instr_opcode(cur_word) == OP_STORE);

  always_comb begin
    state_nxt        = state;
    cpu_opcode       = OP_NOP;
    cpu_addr         = '0;
    cpu_data         = '0;
    cpu_write_enable = 1'b0;
    res_valid        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_go) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        cpu_opcode       = instr_opcode(cur_word);
        cpu_addr         = instr_addr(cur_word);
        cpu_data         = instr_data(cur_word);
        cpu_write_enable = cur_is_store;
        state_nxt        = ST_WAIT;
      end
      ST_WAIT: begin
        // Opcode drops to NOP so the CPU decodes the instruction only once.
        cpu_addr         = instr_addr(cur_word);
        cpu_data         = instr_data(cur_word);
        cpu_write_enable = cur_is_store;
        if (hold_cnt == '0) state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = last_instr ? ST_IDLE : ST_ISSUE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      prog_len  <= '0;
      pc        <= '0;
      hold_cnt  <= '0;
      done      <= 1'b0;
      res_data  <= '0;
      res_index <= '0;
    end else begin
      state <= state_nxt;
      done  <= start_empty || (res_fire && last_instr);

      if (prog_clr && (state == ST_IDLE)) prog_len <= '0;
      else if (load_fire)                 prog_len <= prog_len + 1'b1;

      if (start_go)      pc <= '0;
      else if (res_fire) pc <= last_instr ? '0 : pc + 1'b1;

      if (state == ST_ISSUE)                        hold_cnt <= HOLD_LAST;
      else if ((state == ST_WAIT) && (hold_cnt != '0)) hold_cnt <= hold_cnt - 1'b1;

      if ((state == ST_WAIT) && (hold_cnt == '0)) begin
        res_data  <= cpu_result[7:4];
        res_index <= pc;
      end
    end
  end

endmodule
